sinegen_sweep_ctrl: RTL

Sequencer that drives the `_incr` and `_en` inputs of the sine generator to produce a stepped frequency sweep (chirp).
- Software supplies start/stop/step increments and a dwell time, then pulses `_start`.
- The block steps the phase increment from start toward stop, holding each value for the dwell time.
- It reports progress via `_busy`/`_done` and supports one-shot or looping sweeps and abort.
- It sits between the control/config logic and the sinegen datapath; it does not touch the ROM or counter internals.

---
 rtl/sinegen_sweep_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sinegen_sweep_ctrl.sv
// Stepped-frequency sweep sequencer: walks the sinegen phase increment from a
// start value toward a stop value, holding each value for a programmable dwell.
module sinegen_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               loop_i,
  input  logic [WIDTH-1:0]   incr_start_i,
  input  logic [WIDTH-1:0]   incr_stop_i,
  input  logic [WIDTH-1:0]   incr_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [WIDTH-1:0]   incr_o,
  output logic               en_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic {IDLE, RUN} state_t;

  // Saturating steps: the carry/borrow bit catches wrap, then clamp to stop.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] step,
                                               input logic [WIDTH-1:0] stop);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    step_up = (sum[WIDTH] || (sum[WIDTH-1:0] > stop)) ? stop : sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] step,
                                                 input logic [WIDTH-1:0] stop);
    logic [WIDTH:0] diff;
    diff = {1'b0, cur} - {1'b0, step};
    step_down = (diff[WIDTH] || (diff[WIDTH-1:0] < stop)) ? stop : diff[WIDTH-1:0];
  endfunction

  state_t             state_q;
  logic [WIDTH-1:0]   incr_q, start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic               en_q, busy_q, done_q, loop_q, up_q;

  logic [WIDTH-1:0]   incr_d, step_cap_d;
  logic [DWELL_W-1:0] dwell_cap_d;

  // dwell_q holds the reload value (dwell-1), so the counter expires at zero.
  always_comb begin
    incr_d      = up_q ? step_up(incr_q, step_q, stop_q) : step_down(incr_q, step_q, stop_q);
    step_cap_d  = (incr_step_i == '0) ? WIDTH'(1) : incr_step_i;
    dwell_cap_d = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      incr_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      loop_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i && !abort_i) begin
            start_q <= incr_start_i;
            stop_q  <= incr_stop_i;
            step_q  <= step_cap_d;
            dwell_q <= dwell_cap_d;
            loop_q  <= loop_i;
            up_q    <= (incr_stop_i >= incr_start_i);
            cnt_q   <= dwell_cap_d;
            incr_q  <= incr_start_i;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= IDLE;
            incr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - DWELL_W'(1);
            done_q <= 1'b0;
          end else if (incr_q != stop_q) begin
            incr_q <= incr_d;
            cnt_q  <= dwell_q;
            done_q <= 1'b0;
          end else if (loop_q) begin
            incr_q <= start_q;
            cnt_q  <= dwell_q;
            done_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign incr_o = incr_q;
  assign en_o   = en_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
